aes_axil_regfile: RTL and testbench

//  AXI4-Lite slave register file in front of the AES-128 ECB encryption core.

---
 rtl/aes_axil_regfile_pkg.sv | 51 +++++
 rtl/aes_axil_regfile_if.sv | 37 +++
 rtl/aes_axil_regfile.sv | 177 +++++++++++++++++
 tb/tb_aes_axil_regfile.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_axil_regfile_pkg.sv
// Shared constants, state encodings and helper functions for the AES AXI4-Lite register file.
package aes_axil_pkg;

  // Byte offsets within the 64-byte register window
  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h04;
  localparam logic [5:0] ADDR_KEY0   = 6'h10;
  localparam logic [5:0] ADDR_KEY3   = 6'h1C;
  localparam logic [5:0] ADDR_PT0    = 6'h20;
  localparam logic [5:0] ADDR_PT3    = 6'h2C;
  localparam logic [5:0] ADDR_CT0    = 6'h30;
  localparam logic [5:0] ADDR_CT3    = 6'h3C;

  // Bit positions inside CTRL and STATUS
  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVERRUN = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wfsm_t;
  typedef enum logic {R_IDLE, R_DATA} rfsm_t;

  // Register group selected by a word address
  typedef enum logic [2:0] {SEL_CTRL, SEL_STATUS, SEL_KEY, SEL_PT, SEL_CT, SEL_NONE} sel_t;

  // Word address is byte address [5:2]; the low two bits index within a 4-word group
  function automatic sel_t decode(input logic [3:0] word);
    case (word[3:2])
      2'b00:   return (word[1:0] == 2'd0) ? SEL_CTRL :
                      (word[1:0] == 2'd1) ? SEL_STATUS : SEL_NONE;
      2'b01:   return SEL_KEY;
      2'b10:   return SEL_PT;
      default: return SEL_CT;
    endcase
  endfunction

  // Replace only the bytes whose strobe is set
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/aes_axil_regfile_if.sv
// AXI4-Lite bus bundle between the bus master and the AES register file.
interface aes_axil_regfile_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/aes_axil_regfile.sv
// AXI4-Lite register file in front of an AES-128 core: holds key/plaintext,
// launches the core, captures the ciphertext and reports status/interrupt.
module aes_axil_regfile
  import aes_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_areset,
  aes_axil_regfile_if.slave    s00_axi,
  output logic                 aes_start,
  output logic [127:0]         aes_key,
  output logic [127:0]         aes_pt,
  input  logic                 aes_done,
  input  logic [127:0]         aes_ct,
  output logic                 irq
);

  typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;

  wfsm_t w_state;
  rfsm_t r_state;
  logic  irq_en, busy, done, overrun;
  word_t key [4];
  word_t pt  [4];
  word_t ct  [4];

  logic [C_S_AXI_ADDR_WIDTH-1:2] wr_word, rd_word;
  sel_t  wr_sel, rd_sel;
  logic  wr_fire;
  word_t rd_data;
  logic [1:0] rd_resp;

  assign wr_word = s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_word = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_sel  = decode(wr_word);
  assign rd_sel  = decode(rd_word);

  // Address and data are taken together, only while no response is pending
  assign wr_fire         = (w_state == W_IDLE) && s00_axi.awvalid && s00_axi.wvalid;
  assign s00_axi.awready = wr_fire;
  assign s00_axi.wready  = wr_fire;
  assign s00_axi.arready = (r_state == R_IDLE) && s00_axi.arvalid;

  assign aes_key = {key[0], key[1], key[2], key[3]};
  assign aes_pt  = {pt[0],  pt[1],  pt[2],  pt[3]};
  assign irq     = done & irq_en;

  // Write channel FSM, register updates, core launch and ciphertext capture
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      w_state        <= W_IDLE;
      s00_axi.bvalid <= 1'b0;
      s00_axi.bresp  <= RESP_OKAY;
      aes_start      <= 1'b0;
      irq_en         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overrun        <= 1'b0;
      // NOTE: these word arrays are ordinary flops, not RAM, so they take the async reset.
      for (int i = 0; i < 4; i++) begin
        key[i] <= '0;
        pt[i]  <= '0;
        ct[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking throughout, so every read sees the pre-edge value of busy/done.
      aes_start <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (wr_fire) begin
            w_state        <= W_RESP;
            s00_axi.bvalid <= 1'b1;
            s00_axi.bresp  <= RESP_OKAY;
            case (wr_sel)
              SEL_CTRL: begin
                if (s00_axi.wstrb[0]) begin
                  irq_en <= s00_axi.wdata[CTRL_IRQ_EN];
                  if (s00_axi.wdata[CTRL_START]) begin
                    if (!busy) begin
                      aes_start <= 1'b1;
                      busy      <= 1'b1;
                    end else begin
                      overrun   <= 1'b1;
                    end
                  end
                end
              end
              SEL_STATUS: begin
                if (s00_axi.wstrb[0]) begin
                  if (s00_axi.wdata[STAT_OVERRUN]) overrun <= 1'b0;
                  if (s00_axi.wdata[STAT_DONE])    done    <= 1'b0;
                end
              end
              // Operands are frozen while the core is running
              SEL_KEY: begin
                if (busy) s00_axi.bresp <= RESP_SLVERR;
                else      key[wr_word[3:2]] <= merge_bytes(key[wr_word[3:2]], s00_axi.wdata, s00_axi.wstrb);
              end
              SEL_PT: begin
                if (busy) s00_axi.bresp <= RESP_SLVERR;
                else      pt[wr_word[3:2]] <= merge_bytes(pt[wr_word[3:2]], s00_axi.wdata, s00_axi.wstrb);
              end
              default: s00_axi.bresp <= RESP_SLVERR;
            endcase
          end
        end
        W_RESP: begin
          if (s00_axi.bready) begin
            s00_axi.bvalid <= 1'b0;
            w_state        <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase

      // Placed after the W1C handling so a coincident completion keeps DONE set
      if (aes_done && busy) begin
        ct[0] <= aes_ct[127:96];
        ct[1] <= aes_ct[95:64];
        ct[2] <= aes_ct[63:32];
        ct[3] <= aes_ct[31:0];
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

  // Read data mux for the address presented on the AR channel
  always_comb begin
    // NOTE: defaults first so no path through the case leaves rd_data/rd_resp unassigned.
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      SEL_CTRL:   rd_data[CTRL_IRQ_EN] = irq_en;
      SEL_STATUS: begin
        rd_data[STAT_BUSY]    = busy;
        rd_data[STAT_DONE]    = done;
        rd_data[STAT_OVERRUN] = overrun;
      end
      SEL_KEY:    rd_data = key[rd_word[3:2]];
      SEL_PT:     rd_data = pt[rd_word[3:2]];
      SEL_CT:     rd_data = ct[rd_word[3:2]];
      default:    rd_resp = RESP_SLVERR;
    endcase
  end

  // Read channel FSM; data and response are held until the master takes them
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_state        <= R_IDLE;
      s00_axi.rvalid <= 1'b0;
      s00_axi.rdata  <= '0;
      s00_axi.rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s00_axi.arvalid) begin
            s00_axi.rdata  <= rd_data;
            s00_axi.rresp  <= rd_resp;
            s00_axi.rvalid <= 1'b1;
            r_state        <= R_DATA;
          end
        end
        R_DATA: begin
          if (s00_axi.rready) begin
            s00_axi.rvalid <= 1'b0;
            r_state        <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_axil_regfile.sv
// Directed bench for aes_axil_regfile with a fixed-latency AES core stand-in.
module tb_aes_axil_regfile;
  import aes_axil_pkg::*;

  localparam int TMO = 50;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_ALT = 128'h11111111222222223333333344444444;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_axil_regfile_if bus ();

  logic         aes_start, aes_done, irq;
  logic [127:0] aes_key, aes_pt, aes_ct;
  logic         model_en   = 1'b1;
  logic         model_done;
  logic         man_done   = 1'b0;
  logic [127:0] man_ct     = '0;
  int           model_cnt;
  int           starts     = 0;

  assign aes_done = model_done | man_done;
  assign aes_ct   = man_done ? man_ct : CT_C1;

  aes_axil_regfile dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .s00_axi        (bus.slave),
    .aes_start      (aes_start),
    .aes_key        (aes_key),
    .aes_pt         (aes_pt),
    .aes_done       (aes_done),
    .aes_ct         (aes_ct),
    .irq            (irq)
  );

  // Core stand-in: done pulse 10 cycles after start, returning the C.1 ciphertext
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_cnt  <= 0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (aes_start && model_en) model_cnt <= 10;
      else if (model_cnt > 1)    model_cnt <= model_cnt - 1;
      else if (model_cnt == 1) begin
        model_cnt  <= 0;
        model_done <= 1'b1;
      end
    end
  end

  always @(posedge clk) if (aes_start) starts <= starts + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One AXI write; 'hold' keeps bready low that many cycles, 'with_done' pulses aes_done on the accept edge
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hold, input bit with_done, output logic [1:0] resp);
    int   n;
    logic stable;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    if (with_done) man_done = 1'b1;
    #1;
    n = 0;
    while (!(bus.awready && bus.wready) && n < TMO) begin @(negedge clk); #1; n++; end
    if (n >= TMO) check("write_accept_timeout", n < TMO, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; man_done = 1'b0;
    n = 0;
    while (!bus.bvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check("bvalid_timeout", n < TMO, 1'b1);
    resp = bus.bresp;
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!bus.bvalid || bus.bresp !== resp) stable = 1'b0;
      end
      check("bvalid_bresp_held", stable, 1'b1);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  // One AXI read; 'hold' keeps rready low that many cycles
  task automatic axi_read(input logic [5:0] a, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int   n;
    logic stable;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.arready && n < TMO) begin @(negedge clk); #1; n++; end
    if (n >= TMO) check("read_accept_timeout", n < TMO, 1'b1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check("rvalid_timeout", n < TMO, 1'b1);
    data = bus.rdata;
    resp = bus.rresp;
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!bus.rvalid || bus.rdata !== data || bus.rresp !== resp) stable = 1'b0;
      end
      check("rvalid_rdata_held", stable, 1'b1);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;
  int          s0;
  int          n;

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // 1: reset values
    #100;
    check("rst_handshake", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 5'b0);
    check("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 36'h0);
    check("rst_core_if", {aes_start, irq, aes_key, aes_pt}, 258'h0);
    #100;
    @(negedge clk); rst = 1'b0;
    axi_read(ADDR_KEY0, 0, rd, rsp);
    check("key0_after_reset", {rsp, rd}, {RESP_OKAY, 32'h0});

    // 3: partial strobes over a zero register
    axi_write(6'h14, 32'hAABBCCDD, 4'b0101, 0, 1'b0, rsp);
    check("key1_strb_resp", rsp, RESP_OKAY);
    axi_read(6'h14, 0, rd, rsp);
    check("key1_strb_data", rd, 32'h00BB00DD);

    // 2: FIPS-197 C.1 encryption round trip
    for (int i = 0; i < 4; i++) begin
      axi_write(ADDR_KEY0 + 6'(4*i), KEY_C1[127-32*i -: 32], 4'hF, 0, 1'b0, rsp);
      axi_write(ADDR_PT0  + 6'(4*i), PT_C1[127-32*i -: 32],  4'hF, 0, 1'b0, rsp);
    end
    check("pt3_write_resp", rsp, RESP_OKAY);
    s0 = starts;
    axi_write(ADDR_CTRL, 32'h3, 4'hF, 0, 1'b0, rsp);
    check("start_pulses", starts - s0, 1);
    check("aes_key_out", aes_key, KEY_C1);
    check("aes_pt_out", aes_pt, PT_C1);
    axi_read(ADDR_STATUS, 0, rd, rsp);
    check("status_busy", rd, 32'h1);
    n = 0;
    while (!irq && n < TMO) begin @(negedge clk); n++; end
    check("irq_after_done", irq, 1'b1);
    for (int i = 0; i < 4; i++) begin
      axi_read(ADDR_CT0 + 6'(4*i), 0, rd, rsp);
      check($sformatf("ct%0d", i), {rsp, rd}, {RESP_OKAY, CT_C1[127-32*i -: 32]});
    end
    axi_read(ADDR_STATUS, 0, rd, rsp);
    check("status_done", rd, 32'h2);
    axi_write(ADDR_STATUS, 32'h2, 4'hF, 0, 1'b0, rsp);
    check("irq_cleared", irq, 1'b0);

    // 5: unmapped and read-only offsets
    axi_write(6'h08, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rsp);
    check("wr_0x08_resp", rsp, RESP_SLVERR);
    axi_write(ADDR_CT3, 32'h12345678, 4'hF, 0, 1'b0, rsp);
    check("wr_ct3_resp", rsp, RESP_SLVERR);
    axi_read(ADDR_CT3, 0, rd, rsp);
    check("ct3_unchanged", {rsp, rd}, {RESP_OKAY, CT_C1[31:0]});
    axi_read(6'h0C, 0, rd, rsp);
    check("rd_0x0c", {rsp, rd}, {RESP_SLVERR, 32'h0});
    axi_read(ADDR_STATUS, 0, rd, rsp);
    check("status_after_bad_wr", rd, 32'h0);

    // 6a: stalled response channels
    axi_write(ADDR_KEY0, 32'h00010203, 4'hF, 5, 1'b0, rsp);
    check("stalled_bresp", rsp, RESP_OKAY);
    axi_read(ADDR_CT0, 5, rd, rsp);
    check("stalled_rdata", {rsp, rd}, {RESP_OKAY, CT_C1[127:96]});

    // 4: double start, operand write while busy
    model_en = 1'b0;
    s0 = starts;
    axi_write(ADDR_CTRL, 32'h1, 4'hF, 0, 1'b0, rsp);
    axi_write(ADDR_CTRL, 32'h1, 4'hF, 0, 1'b0, rsp);
    check("restart_resp", rsp, RESP_OKAY);
    check("single_start", starts - s0, 1);
    axi_write(ADDR_PT0, 32'hDEADBEEF, 4'hF, 0, 1'b0, rsp);
    check("pt0_busy_resp", rsp, RESP_SLVERR);
    axi_read(ADDR_STATUS, 0, rd, rsp);
    check("status_overrun_busy", rd, 32'h5);
    axi_read(ADDR_PT0, 0, rd, rsp);
    check("pt0_unchanged", rd, PT_C1[127:96]);

    // 6b: completion on the same edge as a DONE W1C
    man_ct = CT_ALT;
    axi_write(ADDR_STATUS, 32'h2, 4'hF, 0, 1'b1, rsp);
    axi_read(ADDR_STATUS, 0, rd, rsp);
    check("done_set_wins", rd, 32'h6);
    check("irq_disabled", irq, 1'b0);
    axi_read(ADDR_CT0, 0, rd, rsp);
    check("ct0_second_op", rd, CT_ALT[127:96]);
    axi_write(ADDR_STATUS, 32'h6, 4'hF, 0, 1'b0, rsp);
    axi_read(ADDR_STATUS, 0, rd, rsp);
    check("status_all_cleared", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
